// File: rtl/limb_adder_pkg.sv
// Shared types for the limb-serial adder.
// Optional signed-overflow output: define LIMB_SERIAL_OVF_EN.
package limb_adder_pkg;

    localparam int LIMB_W = 8;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    typedef struct packed {
        logic [LIMB_W-1:0] a;
        logic [LIMB_W-1:0] b;
        logic              first;
        logic              last;
        logic              sub;
    } limb_in_t;

    // Signed overflow from operand and result sign bits; this is
    // equivalent to carry-out XOR carry-into-msb.
    function automatic logic signed_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/limb_add8_cin.sv
// 8-bit Kogge-Stone prefix adder with carry-in and carry-out.
// The carry-in is folded into the bit-0 generate term.
module limb_add8_cin
    import limb_adder_pkg::*;
(
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              cin,
    output logic [LIMB_W-1:0] sum,
    output logic              cout
);

    logic [LIMB_W-1:0] gen;
    logic [LIMB_W-1:0] prop;
    logic [LIMB_W-1:0] g0;
    logic [LIMB_W-1:0] g1;
    logic [LIMB_W-1:0] p1;
    logic [LIMB_W-1:0] g2;
    logic [LIMB_W-1:0] p2;
    logic [LIMB_W-1:0] g3;

    // Three prefix levels at spans 1, 2 and 4; g3[i] is the carry
    // out of bit i including the carry-in.
    always_comb begin
        gen  = a & b;
        prop = a ^ b;
        g0   = gen;
        g0[0] = gen[0] | (prop[0] & cin);

        g1 = g0 | (prop & {g0[LIMB_W-2:0], 1'b0});
        p1 = prop & {prop[LIMB_W-2:0], 1'b1};

        g2 = g1 | (p1 & {g1[LIMB_W-3:0], 2'b00});
        p2 = p1 & {p1[LIMB_W-3:0], 2'b11};

        g3 = g2 | (p2 & {g2[LIMB_W-5:0], 4'b0000});

        sum  = prop ^ {g3[LIMB_W-2:0], cin};
        cout = g3[LIMB_W-1];
    end

endmodule

// File: rtl/limb_serial_adder.sv
// Limb-serial multi-word add/subtract, one registered limb per cycle.
// Optional out_ovf port: define LIMB_SERIAL_OVF_EN.
module limb_serial_adder
    import limb_adder_pkg::*;
#(
    parameter int MAX_LIMBS = 16
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LIMB_W-1:0] in_a,
    input  logic [LIMB_W-1:0] in_b,
    input  logic              in_first,
    input  logic              in_last,
    input  logic              in_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LIMB_W-1:0] out_sum,
    output logic              out_last,
    output logic              out_cout,
    output logic              err
`ifdef LIMB_SERIAL_OVF_EN
   ,output logic              out_ovf
`endif
);

    localparam int CNT_W = $clog2(MAX_LIMBS + 1);

    state_t state;
    state_t state_d;

    limb_in_t cur;

    logic             accept;
    logic             first_eff;
    logic             sub_eff;
    logic             cin;
    logic             last_eff;
    logic             cnt_hit;
    logic             err_set;
    logic [LIMB_W-1:0] eff_b;
    logic [LIMB_W-1:0] sum;
    logic             c;

    logic             carry_q;
    logic             sub_q;
    logic [CNT_W-1:0] limb_cnt;
    logic [CNT_W-1:0] cnt_eff;
    logic [CNT_W-1:0] cnt_nxt;

    assign cur = '{
        a:     in_a,
        b:     in_b,
        first: in_first,
        last:  in_last,
        sub:   in_sub
    };

    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    // Next state plus per-limb control: first/last resolution,
    // operand inversion and carry-in selection.
    always_comb begin
        state_d   = state;
        first_eff = 1'b1;
        err_set   = 1'b0;

        unique case (state)
            IDLE: begin
                first_eff = 1'b1;
                err_set   = accept & !cur.first;
            end
            ACTIVE: begin
                first_eff = cur.first;
                err_set   = accept & cur.first;
            end
        endcase

        sub_eff  = first_eff ? cur.sub : sub_q;
        cin      = first_eff ? sub_eff : carry_q;
        eff_b    = sub_eff ? ~cur.b : cur.b;
        cnt_eff  = first_eff ? '0 : limb_cnt;
        cnt_nxt  = cnt_eff + CNT_W'(1);
        cnt_hit  = !cur.last && (cnt_nxt == CNT_W'(MAX_LIMBS));
        last_eff = cur.last | cnt_hit;

        if (accept) begin
            if (cnt_hit) begin
                err_set = 1'b1;
            end
            state_d = last_eff ? IDLE : ACTIVE;
        end
    end

    limb_add8_cin u_add (
        .a    (cur.a),
        .b    (eff_b),
        .cin  (cin),
        .sum  (sum),
        .cout (c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Inter-limb carry, packet mode and limb count.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            limb_cnt <= '0;
        end else if (accept) begin
            if (last_eff) begin
                carry_q  <= 1'b0;
                sub_q    <= 1'b0;
                limb_cnt <= '0;
            end else begin
                carry_q  <= c;
                sub_q    <= sub_eff;
                limb_cnt <= cnt_nxt;
            end
        end
    end

    // Sticky protocol error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

    // Single output register; holds while the sink stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sum   <= sum;
            out_last  <= last_eff;
            out_cout  <= last_eff & c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef LIMB_SERIAL_OVF_EN
    // Signed overflow of the final limb, registered with the sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_ovf <= 1'b0;
        end else if (accept) begin
            out_ovf <= last_eff &
                       signed_ovf(cur.a[LIMB_W-1], eff_b[LIMB_W-1],
                                  sum[LIMB_W-1]);
        end
    end
`endif

endmodule

// File: tb/tb_limb_serial_adder.sv
// Self-checking bench for limb_serial_adder.
// Vector table plus scoreboard; define LIMB_SERIAL_OVF_EN to check out_ovf.
module tb_limb_serial_adder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       first;
        logic       last;
        logic       sub;
        logic [7:0] sum;
        logic       elast;
        logic       cout;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [7:0] sum;
        logic       elast;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_first;
    logic       in_last;
    logic       in_sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_last;
    logic       out_cout;
    logic       err;
`ifdef LIMB_SERIAL_OVF_EN
    logic       out_ovf;
`endif

    logic bp_en = 1'b0;
    logic hold  = 1'b0;

    int total = 0;
    int bad   = 0;

    exp_t sb[$];
    vec_t vt[13];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        out_ready <= bp_en ? 1'($urandom_range(0, 1)) : !hold;
    end

    limb_serial_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .err       (err)
`ifdef LIMB_SERIAL_OVF_EN
       ,.out_ovf   (out_ovf)
`endif
    );

    function automatic vec_t mk(
        input logic [7:0] a, input logic [7:0] b,
        input logic f, input logic l, input logic s,
        input logic [7:0] sum, input logic el,
        input logic co, input logic ov
    );
        vec_t v;
        v.a = a; v.b = b; v.first = f; v.last = l; v.sub = s;
        v.sum = sum; v.elast = el; v.cout = co; v.ovf = ov;
        return v;
    endfunction

    task automatic check(
        input string name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_extra: got sum %0h want none",
                             out_sum);
                end else begin
                    e = sb.pop_front();
                    check("sum", 32'(out_sum), 32'(e.sum));
                    check("last", 32'(out_last), 32'(e.elast));
                    check("cout", 32'(out_cout), 32'(e.cout));
`ifdef LIMB_SERIAL_OVF_EN
                    check("ovf", 32'(out_ovf), 32'(e.ovf));
`endif
                end
            end
        end
    endtask

    task automatic send(input vec_t v);
        bit acc;
        int n;
        in_a     = v.a;
        in_b     = v.b;
        in_first = v.first;
        in_last  = v.last;
        in_sub   = v.sub;
        in_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = (in_ready === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (acc) begin
            sb.push_back('{v.sum, v.elast, v.cout, v.ovf});
        end else begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready got 0 want 1");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain_left", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = mk(8'hFF, 8'h01, 1, 0, 0, 8'h00, 0, 0, 0);
        vt[1]  = mk(8'h12, 8'h00, 0, 1, 0, 8'h13, 1, 0, 0);
        vt[2]  = mk(8'h00, 8'h01, 1, 0, 1, 8'hFF, 0, 0, 0);
        vt[3]  = mk(8'h01, 8'h00, 0, 1, 1, 8'h00, 1, 1, 0);
        vt[4]  = mk(8'hFF, 8'h01, 1, 1, 0, 8'h00, 1, 1, 0);
        vt[5]  = mk(8'h7F, 8'h01, 1, 1, 0, 8'h80, 1, 0, 1);
        vt[6]  = mk(8'h56, 8'hEF, 1, 0, 0, 8'h45, 0, 0, 0);
        vt[7]  = mk(8'h34, 8'hCD, 0, 0, 0, 8'h02, 0, 0, 0);
        vt[8]  = mk(8'h12, 8'hAB, 0, 1, 0, 8'hBE, 1, 0, 0);
        vt[9]  = mk(8'h05, 8'h07, 1, 1, 1, 8'hFE, 1, 0, 0);
        vt[10] = mk(8'h00, 8'h01, 1, 0, 1, 8'hFF, 0, 0, 0);
        vt[11] = mk(8'h00, 8'h00, 0, 0, 1, 8'hFF, 0, 0, 0);
        vt[12] = mk(8'h00, 8'h00, 0, 1, 1, 8'hFF, 1, 0, 0);

        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_first = 1'b0;
        in_last = 1'b0;
        in_sub = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_cout", 32'(out_cout), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) send(vt[i]);
        drain();

        bp_en = 1'b1;
        for (int i = 0; i < 13; i++) send(vt[i]);
        drain();
        bp_en = 1'b0;
        drain();

        hold = 1'b1;
        @(posedge clk);
        #1;
        send(mk(8'h10, 8'h20, 1, 1, 0, 8'h30, 1, 0, 0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(out_sum), 32'h30);
            check("hold_last", 32'(out_last), 32'd1);
        end
        @(posedge clk);
        #1;
        fork
            send(mk(8'h01, 8'h02, 1, 1, 0, 8'h03, 1, 0, 0));
            begin
                repeat (2) @(posedge clk);
                hold = 1'b0;
            end
        join
        drain();

        @(negedge clk);
        check("err_clean", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        send(mk(8'hFF, 8'h01, 1, 0, 0, 8'h00, 0, 0, 0));
        send(mk(8'h10, 8'h20, 1, 1, 0, 8'h30, 1, 0, 0));
        drain();
        @(negedge clk);
        check("err_restart", 32'(err), 32'd1);
        @(posedge clk);
        #1;

        send(mk(8'hFF, 8'h01, 1, 0, 0, 8'h00, 0, 0, 0));
        in_a = 8'h11;
        in_b = 8'h22;
        in_first = 1'b0;
        in_last = 1'b0;
        in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rstmid_valid", 32'(out_valid), 32'd0);
        check("rstmid_err", 32'(err), 32'd0);
        check("rstmid_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(mk(8'hFF, 8'h01, 1, 0, 0, 8'h00, 0, 0, 0));
        send(mk(8'h01, 8'h00, 0, 1, 0, 8'h02, 1, 0, 0));
        drain();
        @(negedge clk);
        check("rstmid_fresh_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            send(mk(8'hFF, (i == 0) ? 8'h01 : 8'h00, (i == 0), 0, 0,
                    8'h00, (i == 15), (i == 15), 0));
        end
        send(mk(8'h05, 8'h03, 1, 1, 0, 8'h08, 1, 0, 0));
        drain();
        @(negedge clk);
        check("ovf_cnt_err", 32'(err), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
